// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port RAM32 macro between the host loader and the serv CPU bus.
// One access at a time, walked through IDLE -> MEM -> CAP -> DONE.
// Optional build macro SRAM_ARB_RR_EN selects round-robin arbitration; otherwise the host wins ties.
module sram_arbiter #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  // host loader port
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic [3:0]    host_wmask,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  // CPU port (byte address)
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [3:0]    cpu_wmask,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  // RAM32 macro pins
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_we,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  // status
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {StIdle, StMem, StCap, StDone} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    mask_q, mask_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          grant_cpu;

  // Byte-lane and out-of-range CPU address bits are deliberately dropped (word index wraps).
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

  // Winner selection; only consulted in IDLE.
`ifdef SRAM_ARB_RR_EN
  // owner_q doubles as history: on contention the previous non-owner wins.
  assign grant_cpu = cpu_req & (~host_req | ~owner_q);
`else
  assign grant_cpu = cpu_req & ~host_req;
`endif

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      host_rdata_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      host_rdata_q <= host_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // Next-state logic: grant and latch in IDLE, capture read data in CAP.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    host_rdata_d = host_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (host_req || cpu_req) begin
          owner_d = grant_cpu;
          if (grant_cpu) begin
            we_d    = cpu_we;
            addr_d  = cpu_addr[AW+1:2];
            wdata_d = cpu_wdata;
            mask_d  = cpu_wmask;
          end else begin
            we_d    = host_we;
            addr_d  = host_addr;
            wdata_d = host_wdata;
            mask_d  = host_wmask;
          end
          state_d = StMem;
        end
      end
      StMem: state_d = StCap;
      StCap: begin
        // ram_do is valid one cycle after the enable edge; writes leave rdata untouched.
        if (!we_q) begin
          if (owner_q) cpu_rdata_d = ram_do;
          else         host_rdata_d = ram_do;
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded purely from registered state, so no req-to-RAM/ack combinational path.
  always_comb begin
    ram_en     = (state_q == StMem);
    ram_we     = (state_q == StMem && we_q) ? mask_q : 4'b0000;
    ram_addr   = addr_q;
    ram_di     = wdata_q;
    host_ack   = (state_q == StDone) && !owner_q;
    cpu_ack    = (state_q == StDone) && owner_q;
    host_rdata = host_rdata_q;
    cpu_rdata  = cpu_rdata_q;
    busy       = (state_q != StIdle);
    owner      = owner_q;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port RAM32 macro between two requesters: the UART-side host loader (SRAM controller path) and the serv CPU bus (sram_addr/sram_cs/sram_we/sram_wmask/sram_ack style).
- Each requester gets a hold-until-ack request/acknowledge handshake.
- Exactly one access is in flight at a time. The block owns the RAM's EN0/A0/WE0/Di0 pins and returns registered read data and a one-cycle ack to the granted requester.

Parameters:
- AW, 5, RAM word-address width (RAM32 = 32 words).
- DW, 32, data width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- host_req  input  1  host request; held high until host_ack
- host_we  input  1  1 = write, 0 = read
- host_addr  input  AW  host word address
- host_wdata  input  DW  host write data
- host_wmask  input  4  host byte-write mask
- host_rdata  output  DW  host read data, valid while host_ack = 1
- host_ack  output  1  one-cycle completion pulse
- cpu_req  input  1  CPU request (serv sram_cs); held until cpu_ack
- cpu_we  input  1  CPU write
- cpu_addr  input  32  CPU byte address
- cpu_wdata  input  DW  CPU write data
- cpu_wmask  input  4  CPU byte mask
- cpu_rdata  output  DW  CPU read data, valid while cpu_ack = 1
- cpu_ack  output  1  one-cycle completion pulse
- ram_en  output  1  RAM32 EN0
- ram_addr  output  AW  RAM32 A0
- ram_we  output  4  RAM32 WE0 (byte mask)
- ram_di  output  DW  RAM32 Di0
- ram_do  input  DW  RAM32 Do0; valid the cycle after the EN0 edge
- busy  output  1  high in any state other than IDLE
- owner  output  1  0 = host, 1 = CPU; last/current grant

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - state = IDLE; ram_en = 0; ram_we = 0; ram_addr = 0; ram_di = 0.
  - host_ack = cpu_ack = 0; host_rdata = cpu_rdata = 0.
  - owner = 0; busy = 0.
- FSM states: IDLE -> MEM -> CAP -> DONE -> IDLE.
- IDLE:
  - If any req is high, select a winner (see arbitration).
  - Latch the winner's we, address, wdata and mask into internal registers and set owner.
  - Go to MEM. With no req, stay in IDLE.
- MEM (one cycle):
  - ram_en = 1; ram_addr = latched address.
  - ram_we = latched mask if write, else 0; ram_di = latched wdata.
  - Go to CAP.
- CAP:
  - ram_en = 0, ram_we = 0.
  - For a read, capture ram_do into the owner's rdata register. For a write, the rdata register keeps its previous value.
  - Go to DONE.
- DONE:
  - Owner's ack = 1 for exactly this cycle; the other ack stays 0. Go to IDLE.
- Outputs are decoded from registered state and owner only; there is no combinational path from req to RAM or ack.
- Latency: req seen high in IDLE at cycle t -> RAM enabled at t+1 -> ack high at t+3. Back-to-back accesses are 4 cycles each.
- Requester rule: keep req high and inputs stable until ack; drop req in the cycle after ack.
  - The arbiter samples req in IDLE only, so a req still high during DONE is not re-granted until IDLE.
  - A requester that holds req high past ack gets a new access.
- CPU address mapping: word address = cpu_addr[AW+1:2]. Bits [1:0] and bits above AW+1 are ignored (the address wraps modulo 32 words).
- Arbitration when both req are high in IDLE: fixed priority, host wins. The CPU waits in the handshake (no ack) until host_req is low in an IDLE cycle.
- A req that drops before its grant is ignored. A req that drops mid-access still completes the RAM access; ack is still pulsed.
- reset asserted in any state: the next state is IDLE with all outputs at reset values. An in-flight write may or may not have reached the RAM; no ack is issued.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request in IDLE, the requester that was not the previous owner wins. The owner register serves as history; its reset value of 0 means the first contention goes to the CPU.
- Undefined: fixed host priority as above.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Host write addr 5, data 0xDEADBEEF, mask 4'hF, then host read addr 5 -> ram_en high exactly 1 cycle per access; read host_rdata = 0xDEADBEEF with host_ack 3 cycles after the request; cpu_ack stays 0.
- CPU write cpu_addr 0x0000_0088, data 0x11223344, mask 4'b0011, over prior word 0xAAAAAAAA -> ram_addr = 2, ram_we = 4'b0011; a following CPU read returns 0xAAAA3344.
- host_req and cpu_req rise in the same cycle, both reads -> default build: host_ack at t+3, cpu_ack at t+7. With SRAM_ARB_RR_EN and owner reset: cpu_ack at t+3, host_ack at t+7.
- CPU holds cpu_req high for 3 accesses while the host requests continuously, RR build -> grants alternate host/CPU; neither requester waits more than 1 access.
- reset pulsed for 1 cycle while in MEM on a host write -> next cycle state IDLE, ram_en = 0, no host_ack. With host_req still high, the access restarts and acks 3 cycles after reset drops.
- cpu_addr 0xFFFF_FF80 (word 0) read -> ram_addr = 0; data equals the word written at host_addr 0.
